store_buffer: RTL and testbench

- 4-entry in-order FIFO holding committed sw instructions between ROB commit and the data-cache write port.
- Assigns each committed store an SB tag (SBTag_counter) on entry.
- On completion of the memory write, announces departure with SB_FlushSw/SB_FlushSwTag so the store address buffer can retire its matching entry.
- Contents are architecturally committed, so the block has no CDB flush input.

---
 rtl/store_buffer.sv | 97 +++++++++
 tb/tb_store_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// In-order buffer of committed stores awaiting their data-cache write.
// Entries drain one at a time; each departure is announced with its SB tag.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Resetb,
  input  logic              Rob_CommitMemWrite,
  input  logic [ADDR_W-1:0] Rob_SwAddr,
  input  logic [DATA_W-1:0] Rob_SwData,
  output logic              SB_Full,
  output logic [TAG_W-1:0]  SBTag_counter,
  output logic              SB_FlushSw,
  output logic [TAG_W-1:0]  SB_FlushSwTag,
  output logic              SB_WriteReq,
  output logic [ADDR_W-1:0] SB_AddrDmem,
  output logic [DATA_W-1:0] SB_DataDmem,
  input  logic              DCE_WriteBusy,
  input  logic              DCE_WriteDone
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state, stateNext;
  logic [DEPTH-1:0]    validMem;
  logic [ADDR_W-1:0]   addrMem [DEPTH];
  logic [DATA_W-1:0]   dataMem [DEPTH];
  logic [TAG_W-1:0]    tagMem  [DEPTH];
  logic [TAG_W-1:0]    headPtr, tailPtr, tagCnt;
  logic [TAG_W:0]      count;
  logic                enq, pop;

  assign SB_Full       = (count == (TAG_W+1)'(DEPTH));
  assign enq           = Rob_CommitMemWrite & ~SB_Full;
  assign pop           = (state == WAIT) & DCE_WriteDone;
  assign SB_FlushSw    = pop;
  assign SB_FlushSwTag = pop ? tagMem[headPtr] : '0;
  assign SB_WriteReq   = (state == REQ);
  assign SB_AddrDmem   = addrMem[headPtr];
  assign SB_DataDmem   = dataMem[headPtr];
  assign SBTag_counter = tagCnt;

  // Control state: pointers, valids, occupancy, tag counter, drain FSM
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      validMem <= '0;
      headPtr  <= '0;
      tailPtr  <= '0;
      tagCnt   <= '0;
      count    <= '0;
      state    <= IDLE;
    end else begin
      state <= stateNext;
      if (pop) begin
        validMem[headPtr] <= 1'b0;
        headPtr           <= headPtr + 1'b1;
      end
      if (enq) begin
        validMem[tailPtr] <= 1'b1;
        tailPtr           <= tailPtr + 1'b1;
        tagCnt            <= tagCnt + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; valid bits qualify it
  always_ff @(posedge Clk) begin
    if (enq) begin
      addrMem[tailPtr] <= Rob_SwAddr;
      dataMem[tailPtr] <= Rob_SwData;
      tagMem[tailPtr]  <= tagCnt;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (validMem[headPtr]) stateNext = REQ;
      REQ:  if (!DCE_WriteBusy) stateNext = WAIT;
      WAIT: begin
        // A same-cycle commit also counts as an entry left after the pop
        if (DCE_WriteDone)
          stateNext = ((count > (TAG_W+1)'(1)) || enq) ? REQ : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: commits are queued as they are accepted,
// and cache requests / flush pulses are checked against the queue head.
module tb_store_buffer;

  localparam int DEPTH = 4, TAG_W = 2, ADDR_W = 32, DATA_W = 32;

  logic              Clk, Resetb;
  logic              Rob_CommitMemWrite;
  logic [ADDR_W-1:0] Rob_SwAddr;
  logic [DATA_W-1:0] Rob_SwData;
  logic              SB_Full, SB_FlushSw, SB_WriteReq;
  logic [TAG_W-1:0]  SBTag_counter, SB_FlushSwTag;
  logic [ADDR_W-1:0] SB_AddrDmem;
  logic [DATA_W-1:0] SB_DataDmem;
  logic              DCE_WriteBusy, DCE_WriteDone;

  store_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Resetb(Resetb),
    .Rob_CommitMemWrite(Rob_CommitMemWrite), .Rob_SwAddr(Rob_SwAddr), .Rob_SwData(Rob_SwData),
    .SB_Full(SB_Full), .SBTag_counter(SBTag_counter),
    .SB_FlushSw(SB_FlushSw), .SB_FlushSwTag(SB_FlushSwTag),
    .SB_WriteReq(SB_WriteReq), .SB_AddrDmem(SB_AddrDmem), .SB_DataDmem(SB_DataDmem),
    .DCE_WriteBusy(DCE_WriteBusy), .DCE_WriteDone(DCE_WriteDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
  } ent_t;

  ent_t             q[$];
  int               tests = 0, fails = 0;
  int               mCount = 0, flushCnt = 0;
  logic [TAG_W-1:0] mTag = '0, lastTag = '0;
  logic             accepted = 1'b0, enqM;

  // Scoreboard monitor: samples just before each rising edge
  always @(negedge Clk) begin
    #3;
    if (Resetb !== 1'b1) begin
      q.delete(); mCount = 0; mTag = '0; accepted = 1'b0;
    end else begin
      tests++;
      if (SB_Full !== (mCount == DEPTH)) begin
        fails++; $display("FAIL full_flag: got %0b expected %0b", SB_Full, (mCount == DEPTH));
      end
      tests++;
      if (SBTag_counter !== mTag) begin
        fails++; $display("FAIL tag_counter: got %0d expected %0d", SBTag_counter, mTag);
      end
      enqM = Rob_CommitMemWrite && (mCount != DEPTH);
      if (SB_WriteReq === 1'b1) begin
        tests++;
        if (accepted || q.size() == 0) begin
          fails++; $display("FAIL req_unexpected: got req=1 expected req=0 (queue %0d)", q.size());
        end else if (SB_AddrDmem !== q[0].a || SB_DataDmem !== q[0].d) begin
          fails++;
          $display("FAIL req_payload: got %0h/%0h expected %0h/%0h", SB_AddrDmem, SB_DataDmem, q[0].a, q[0].d);
        end
        if (!DCE_WriteBusy) accepted = 1'b1;
      end
      if (SB_FlushSw === 1'b1) begin
        tests++;
        if (!accepted || q.size() == 0) begin
          fails++; $display("FAIL flush_unexpected: got flush=1 expected flush=0");
        end else if (SB_FlushSwTag !== q[0].t) begin
          fails++; $display("FAIL flush_tag: got %0d expected %0d", SB_FlushSwTag, q[0].t);
        end
        if (q.size() > 0) begin
          lastTag = SB_FlushSwTag;
          void'(q.pop_front());
          mCount--;
        end
        accepted = 1'b0;
        flushCnt++;
      end
      if (enqM) begin
        q.push_back('{Rob_SwAddr, Rob_SwData, mTag});
        mTag = mTag + 1'b1;
        mCount++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge Clk);
    Resetb = 1'b0; Rob_CommitMemWrite = 1'b0; DCE_WriteBusy = 1'b1; DCE_WriteDone = 1'b0;
    @(negedge Clk);
    Resetb = 1'b1;
  endtask

  task automatic doCommit(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge Clk);
    Rob_CommitMemWrite = 1'b1; Rob_SwAddr = a; Rob_SwData = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      Rob_CommitMemWrite = 1'b0; DCE_WriteDone = 1'b0;
    end
  endtask

  task automatic waitReq();
    int k = 0;
    while (SB_WriteReq !== 1'b1 && k < 40) begin
      @(negedge Clk); Rob_CommitMemWrite = 1'b0; k++;
    end
    if (k >= 40) begin
      fails++; tests++; $display("FAIL req_timeout: got req=0 expected req=1");
    end
  endtask

  // Accept each request on first sight, Done in the following cycle
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Rob_CommitMemWrite = 1'b0; DCE_WriteDone = 1'b0;
      waitReq();
      DCE_WriteBusy = 1'b0;
      @(negedge Clk);
      DCE_WriteBusy = 1'b1; DCE_WriteDone = 1'b1;
    end
    @(negedge Clk);
    DCE_WriteDone = 1'b0;
  endtask

  task automatic test_reset();
    Resetb = 1'b1; Rob_CommitMemWrite = 1'b0; Rob_SwAddr = '0; Rob_SwData = '0;
    DCE_WriteBusy = 1'b0; DCE_WriteDone = 1'b0;
    #1 Resetb = 1'b0;
    #2;
    tests++; if (SB_Full !== 1'b0) begin fails++; $display("FAIL rst_full: got %0b expected 0", SB_Full); end
    tests++; if (SB_FlushSw !== 1'b0) begin fails++; $display("FAIL rst_flush: got %0b expected 0", SB_FlushSw); end
    tests++; if (SB_WriteReq !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b expected 0", SB_WriteReq); end
    tests++; if (SB_FlushSwTag !== 2'd0) begin fails++; $display("FAIL rst_ftag: got %0d expected 0", SB_FlushSwTag); end
    tests++; if (SBTag_counter !== 2'd0) begin fails++; $display("FAIL rst_tagcnt: got %0d expected 0", SBTag_counter); end
    @(negedge Clk);
    Resetb = 1'b1;
  endtask

  task automatic test_single();
    int f0;
    apply_reset();
    f0 = flushCnt;
    DCE_WriteBusy = 1'b0;
    doCommit(32'h100, 32'hDEADBEEF);
    #4;
    tests++; if (SBTag_counter !== 2'd0) begin fails++; $display("FAIL single_tag0: got %0d expected 0", SBTag_counter); end
    idle(1);
    #4;
    tests++; if (SBTag_counter !== 2'd1) begin fails++; $display("FAIL single_tag1: got %0d expected 1", SBTag_counter); end
    serve(1);
    idle(2);
    tests++; if (flushCnt - f0 !== 1) begin fails++; $display("FAIL single_flushes: got %0d expected 1", flushCnt - f0); end
    tests++; if (lastTag !== 2'd0) begin fails++; $display("FAIL single_ftag: got %0d expected 0", lastTag); end
    tests++; if (SB_WriteReq !== 1'b0) begin fails++; $display("FAIL single_drained: got req=%0b expected 0", SB_WriteReq); end
  endtask

  task automatic test_full();
    int f0;
    apply_reset();
    f0 = flushCnt;
    for (int i = 0; i < 4; i++) doCommit(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
    doCommit(32'h300, 32'hBAD);
    #4;
    tests++; if (SB_Full !== 1'b1) begin fails++; $display("FAIL full_after4: got %0b expected 1", SB_Full); end
    idle(1);
    #4;
    tests++; if (SBTag_counter !== 2'd0) begin fails++; $display("FAIL full_5th_tag: got %0d expected 0", SBTag_counter); end
    serve(4);
    idle(2);
    tests++; if (flushCnt - f0 !== 4) begin fails++; $display("FAIL full_flushes: got %0d expected 4", flushCnt - f0); end
    tests++; if (lastTag !== 2'd3) begin fails++; $display("FAIL full_lasttag: got %0d expected 3", lastTag); end
    tests++; if (SB_Full !== 1'b0) begin fails++; $display("FAIL full_drained: got %0b expected 0", SB_Full); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 4; i++) doCommit(32'h400 + 32'(4 * i), 32'hB0 + 32'(i));
    idle(1);
    waitReq();
    DCE_WriteBusy = 1'b0;
    @(negedge Clk);
    DCE_WriteBusy = 1'b1; DCE_WriteDone = 1'b1;
    Rob_CommitMemWrite = 1'b1; Rob_SwAddr = 32'h500; Rob_SwData = 32'h55;
    #4;
    tests++; if (SB_Full !== 1'b1) begin fails++; $display("FAIL wrap_full_done: got %0b expected 1", SB_Full); end
    tests++; if (SB_FlushSw !== 1'b1) begin fails++; $display("FAIL wrap_flush: got %0b expected 1", SB_FlushSw); end
    @(negedge Clk);
    DCE_WriteDone = 1'b0; Rob_SwAddr = 32'h504; Rob_SwData = 32'h56;
    #4;
    tests++; if (SB_Full !== 1'b0) begin fails++; $display("FAIL wrap_freed: got %0b expected 0", SB_Full); end
    tests++; if (SBTag_counter !== 2'd0) begin fails++; $display("FAIL wrap_tag: got %0d expected 0", SBTag_counter); end
    idle(1);
    #4;
    tests++; if (SBTag_counter !== 2'd1) begin fails++; $display("FAIL wrap_tag_next: got %0d expected 1", SBTag_counter); end
    serve(4);
    idle(2);
    tests++; if (lastTag !== 2'd0) begin fails++; $display("FAIL wrap_lasttag: got %0d expected 0", lastTag); end
  endtask

  task automatic test_enq_pop();
    apply_reset();
    doCommit(32'h600, 32'hC0);
    doCommit(32'h604, 32'hC1);
    idle(1);
    waitReq();
    DCE_WriteBusy = 1'b0;
    @(negedge Clk);
    DCE_WriteBusy = 1'b1; DCE_WriteDone = 1'b1;
    Rob_CommitMemWrite = 1'b1; Rob_SwAddr = 32'h608; Rob_SwData = 32'hC2;
    #4;
    tests++; if (SB_FlushSw !== 1'b1) begin fails++; $display("FAIL ep_flush: got %0b expected 1", SB_FlushSw); end
    @(negedge Clk);
    DCE_WriteDone = 1'b0; Rob_SwAddr = 32'h60C; Rob_SwData = 32'hC3;
    #4;
    tests++; if (SB_Full !== 1'b0) begin fails++; $display("FAIL ep_count2: got %0b expected 0", SB_Full); end
    @(negedge Clk);
    Rob_SwAddr = 32'h610; Rob_SwData = 32'hC4;
    #4;
    tests++; if (SB_Full !== 1'b0) begin fails++; $display("FAIL ep_count3: got %0b expected 0", SB_Full); end
    idle(1);
    #4;
    tests++; if (SB_Full !== 1'b1) begin fails++; $display("FAIL ep_count4: got %0b expected 1", SB_Full); end
    tests++; if (SBTag_counter !== 2'd1) begin fails++; $display("FAIL ep_tagcnt: got %0d expected 1", SBTag_counter); end
    serve(4);
    idle(2);
    tests++; if (lastTag !== 2'd0) begin fails++; $display("FAIL ep_lasttag: got %0d expected 0", lastTag); end
  endtask

  task automatic test_busy_toggle();
    int f0;
    apply_reset();
    f0 = flushCnt;
    @(negedge Clk);
    DCE_WriteDone = 1'b1;
    #4;
    tests++; if (SB_FlushSw !== 1'b0) begin fails++; $display("FAIL stray_done_idle: got %0b expected 0", SB_FlushSw); end
    @(negedge Clk);
    DCE_WriteDone = 1'b0;
    doCommit(32'h700, 32'h77);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      DCE_WriteBusy = 1'b1; DCE_WriteDone = (i % 2 == 0);
      #4;
      tests++;
      if (SB_WriteReq !== 1'b1 || SB_AddrDmem !== 32'h700 || SB_FlushSw !== 1'b0) begin
        fails++;
        $display("FAIL busy_hold: got req=%0b addr=%0h flush=%0b expected req=1 addr=700 flush=0", SB_WriteReq, SB_AddrDmem, SB_FlushSw);
      end
    end
    serve(1);
    idle(2);
    tests++; if (flushCnt - f0 !== 1) begin fails++; $display("FAIL busy_flushes: got %0d expected 1", flushCnt - f0); end
  endtask

  task automatic test_reset_wait();
    int f0;
    apply_reset();
    for (int i = 0; i < 3; i++) doCommit(32'h800 + 32'(4 * i), 32'hE0 + 32'(i));
    idle(1);
    waitReq();
    DCE_WriteBusy = 1'b0;
    @(negedge Clk);
    DCE_WriteBusy = 1'b1;
    f0 = flushCnt;
    Resetb = 1'b0; DCE_WriteDone = 1'b1;
    #1;
    tests++; if (SB_WriteReq !== 1'b0) begin fails++; $display("FAIL rw_req: got %0b expected 0", SB_WriteReq); end
    tests++; if (SB_FlushSw !== 1'b0) begin fails++; $display("FAIL rw_flush: got %0b expected 0", SB_FlushSw); end
    tests++; if (SB_Full !== 1'b0) begin fails++; $display("FAIL rw_full: got %0b expected 0", SB_Full); end
    tests++; if (SBTag_counter !== 2'd0) begin fails++; $display("FAIL rw_tagcnt: got %0d expected 0", SBTag_counter); end
    tests++; if (SB_FlushSwTag !== 2'd0) begin fails++; $display("FAIL rw_ftag: got %0d expected 0", SB_FlushSwTag); end
    @(negedge Clk);
    Resetb = 1'b1; DCE_WriteDone = 1'b0;
    idle(2);
    tests++; if (flushCnt !== f0) begin fails++; $display("FAIL rw_noflush: got %0d expected %0d", flushCnt, f0); end
    doCommit(32'h900, 32'h99);
    serve(1);
    idle(2);
    tests++; if (lastTag !== 2'd0) begin fails++; $display("FAIL rw_after_tag: got %0d expected 0", lastTag); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_full_wrap();
    test_enq_pop();
    test_busy_toggle();
    test_reset_wait();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
